// File: rtl/ldpc_decoder.sv
// Hard-decision bit-flipping decoder for the 16-bit (8 msg + 8 parity) LDPC code; one flip per ITER cycle.
// Result registered in DONE and held until out_ready; in_ready only in IDLE.
module ldpc_decoder #(
  parameter int MAX_ITER = 4,
  parameter int ITER_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       c_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        m_out,
  output logic              corrected,
  output logic              fail,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  // Column j = the set of check rows that include message bit m_j.
  localparam logic [7:0] COL_MASK [8] = '{8'h1F, 8'h67, 8'hCC, 8'h96,
                                          8'h3B, 8'hE9, 8'h55, 8'hAA};

  state_t            state_q, state_d;
  logic [15:0]       work_q, work_d;
  logic [7:0]        m_out_q, m_out_d;
  logic              corrected_q, corrected_d;
  logic              fail_q, fail_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [7:0] syn;
  logic [3:0] u_tmp;
  logic [3:0] best_u;
  logic [3:0] best_deg;
  logic [2:0] best_idx;
  logic       eligible;

  always_comb begin
    syn = work_q[7:0];
    for (int j = 0; j < 8; j++) begin
      if (work_q[8+j]) syn = syn ^ COL_MASK[j];
    end
  end

  // Ascending scan with >= makes ties land on the highest index.
  always_comb begin
    u_tmp    = 4'd0;
    best_u   = 4'd0;
    best_idx = 3'd0;
    for (int j = 0; j < 8; j++) begin
      u_tmp = 4'($countones(syn & COL_MASK[j]));
      if (u_tmp >= best_u) begin
        best_u   = u_tmp;
        best_idx = 3'(j);
      end
    end
    best_deg = 4'($countones(COL_MASK[best_idx]));
    eligible = ({best_u, 1'b0} > {1'b0, best_deg});
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    m_out_d     = m_out_q;
    corrected_d = corrected_q;
    fail_d      = fail_q;
    iter_cnt_d  = iter_cnt_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d      = c_in;
          iter_cnt_d  = '0;
          corrected_d = 1'b0;
          fail_d      = 1'b0;
          in_ready_d  = 1'b0;
          state_d     = ITER;
        end
      end
      ITER: begin
        if (syn == 8'h00) begin
          fail_d = 1'b0;
        end else if ($countones(syn) == 1) begin
          corrected_d = 1'b1;
          fail_d      = 1'b0;
        end else if (!eligible) begin
          fail_d = 1'b1;
        end else if (iter_cnt_q == ITER_W'(MAX_ITER)) begin
          fail_d = 1'b1;
        end else begin
          work_d[{1'b1, best_idx}] = ~work_q[{1'b1, best_idx}];
          iter_cnt_d  = iter_cnt_q + ITER_W'(1);
          corrected_d = 1'b1;
        end
        // Any branch that did not flip finishes the word.
        if (work_d == work_q) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          m_out_d     = work_q[15:8];
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      m_out_q     <= '0;
      corrected_q <= 1'b0;
      fail_q      <= 1'b0;
      iter_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      m_out_q     <= m_out_d;
      corrected_q <= corrected_d;
      fail_q      <= fail_d;
      iter_cnt_q  <= iter_cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign m_out     = m_out_q;
  assign corrected = corrected_q;
  assign fail      = fail_q;
  assign iter_cnt  = iter_cnt_q;
  assign out_valid = out_valid_q;

endmodule
